// File: rtl/systolic_pkg.sv
// rtl/systolic_pkg.sv - shared state encoding, derived constants and width helper for the tiled systolic sequencer
package systolic_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        FLUSH,
        DRAIN,
        NEXT,
        DONE
    } state_t;

    localparam int DEF_WIDTH  = 4;
    localparam int DEF_HEIGHT = 4;
    localparam int DEF_M_SIZE = 12;
    localparam int DEF_N_SIZE = 12;
    localparam int DEF_K_SIZE = 16;

    localparam int TILES_M   = DEF_M_SIZE / DEF_HEIGHT;
    localparam int TILES_N   = DEF_N_SIZE / DEF_WIDTH;
    localparam int FLUSH_CYC = DEF_WIDTH + DEF_HEIGHT - 2;

    // Counter width that never collapses to zero bits for single-value ranges.
    function automatic int cw(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int K_W  = cw(DEF_K_SIZE);
    localparam int TM_W = cw(TILES_M);
    localparam int TN_W = cw(TILES_N);

endpackage

// File: rtl/tile_counter.sv
// rtl/tile_counter.sv - row-major 2-D wrapping (tile_m, tile_n) counter with look-ahead next values
module tile_counter
    import systolic_pkg::*;
#(
    parameter int TILES_M = 3,
    parameter int TILES_N = 3,
    localparam int MW = cw(TILES_M),
    localparam int NW = cw(TILES_N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [MW-1:0] tile_m,
    output logic [NW-1:0] tile_n,
    output logic [MW-1:0] m_nxt,
    output logic [NW-1:0] n_nxt,
    output logic          last
);

    logic m_end;
    logic n_end;

    assign m_end = (tile_m == MW'(TILES_M - 1));
    assign n_end = (tile_n == NW'(TILES_N - 1));
    assign last  = m_end && n_end;

    // Next values are exported so the top can register base products in step with the counters.
    always_comb begin
        m_nxt = tile_m;
        n_nxt = tile_n;
        if (clr) begin
            m_nxt = '0;
            n_nxt = '0;
        end else if (inc) begin
            if (n_end) begin
                n_nxt = '0;
                m_nxt = m_end ? '0 : tile_m + 1'b1;
            end else begin
                n_nxt = tile_n + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tile_m <= '0;
            tile_n <= '0;
        end else begin
            tile_m <= m_nxt;
            tile_n <= n_nxt;
        end
    end

endmodule

// File: rtl/tile_scheduler.sv
// rtl/tile_scheduler.sv - clear/feed/flush/drain sequencer walking the output matrix tile by tile
module tile_scheduler
    import systolic_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int HEIGHT = 4,
    parameter int M_SIZE = 12,
    parameter int N_SIZE = 12,
    parameter int K_SIZE = 16,
    localparam int KW  = cw(K_SIZE),
    localparam int TMW = cw(M_SIZE / HEIGHT),
    localparam int TNW = cw(N_SIZE / WIDTH),
    localparam int AW  = cw(M_SIZE),
    localparam int BW  = cw(N_SIZE),
    localparam int DW  = cw(HEIGHT)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic           abort,
    output logic           busy,
    output logic           acc_clr,
    output logic           feed_en,
    output logic [KW-1:0]  k_idx,
    output logic [TMW-1:0] tile_m,
    output logic [TNW-1:0] tile_n,
    output logic [AW-1:0]  a_row_base,
    output logic [BW-1:0]  b_col_base,
    output logic           drain_valid,
    input  logic           drain_ready,
    output logic [DW-1:0]  drain_row,
    output logic           tile_done,
    output logic           done
);

    localparam int T_M     = M_SIZE / HEIGHT;
    localparam int T_N     = N_SIZE / WIDTH;
    localparam int FLUSH_N = WIDTH + HEIGHT - 2;
    localparam int FW      = cw(FLUSH_N);

    if ((M_SIZE % HEIGHT) != 0 || (N_SIZE % WIDTH) != 0 || K_SIZE < 1) begin : g_bad_params
        $fatal(1, "tile_scheduler: matrix sizes must be tile multiples and K_SIZE >= 1");
    end

    state_t         state;
    logic [KW-1:0]  k_cnt;
    logic [FW-1:0]  flush_cnt;
    logic [DW-1:0]  drain_cnt;
    logic [TMW-1:0] m_nxt;
    logic [TNW-1:0] n_nxt;
    logic           last_tile;

    tile_counter #(
        .TILES_M (T_M),
        .TILES_N (T_N)
    ) u_tiles (
        .clk    (clk),
        .rst    (rst),
        .inc    (state == NEXT),
        .clr    (abort || state == DONE),
        .tile_m (tile_m),
        .tile_n (tile_n),
        .m_nxt  (m_nxt),
        .n_nxt  (n_nxt),
        .last   (last_tile)
    );

    // Abort shares the reset path so it overrides any beat or transition in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || abort) begin
            state     <= IDLE;
            k_cnt     <= '0;
            flush_cnt <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                IDLE:  if (start) state <= CLEAR;
                CLEAR: begin
                    k_cnt <= '0;
                    state <= FEED;
                end
                FEED: begin
                    if (k_cnt == KW'(K_SIZE - 1)) begin
                        k_cnt     <= '0;
                        flush_cnt <= '0;
                        state     <= (FLUSH_N == 0) ? DRAIN : FLUSH;
                    end else begin
                        k_cnt <= k_cnt + 1'b1;
                    end
                end
                FLUSH: begin
                    if (flush_cnt == FW'(FLUSH_N - 1)) begin
                        flush_cnt <= '0;
                        drain_cnt <= '0;
                        state     <= DRAIN;
                    end else begin
                        flush_cnt <= flush_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_ready) begin
                        if (drain_cnt == DW'(HEIGHT - 1)) begin
                            drain_cnt <= '0;
                            state     <= NEXT;
                        end else begin
                            drain_cnt <= drain_cnt + 1'b1;
                        end
                    end
                end
                NEXT:    state <= last_tile ? DONE : CLEAR;
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Bases follow the counters' next values so they are already correct in CLEAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_row_base <= '0;
            b_col_base <= '0;
        end else begin
            a_row_base <= AW'(int'(m_nxt) * HEIGHT);
            b_col_base <= BW'(int'(n_nxt) * WIDTH);
        end
    end

    assign busy        = (state != IDLE);
    assign acc_clr     = (state == CLEAR);
    assign feed_en     = (state == FEED);
    assign k_idx       = k_cnt;
    assign drain_valid = (state == DRAIN);
    assign drain_row   = drain_cnt;
    assign tile_done   = (state == NEXT);
    assign done        = (state == DONE);

endmodule

// File: tb/tb_tile_scheduler.sv
// tb/tb_tile_scheduler.sv - directed self-checking bench for tile_scheduler
module tb_tile_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       drain_ready = 1'b1;
    logic       busy, acc_clr, feed_en, drain_valid, tile_done, done;
    logic [3:0] k_idx, a_row_base, b_col_base;
    logic [1:0] tile_m, tile_n, drain_row;

    logic       start2 = 1'b0;
    logic       busy2, acc_clr2, feed_en2, drain_valid2, tile_done2, done2;
    logic [0:0] k_idx2, tile_m2, tile_n2;
    logic [1:0] a_row_base2, b_col_base2, drain_row2;

    int n_pass  = 0;
    int n_total = 0;
    int n_done  = 0;
    int n_tdone = 0;
    int cyc     = 0;

    always #5 clk = ~clk;

    tile_scheduler dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .busy(busy),
        .acc_clr(acc_clr), .feed_en(feed_en), .k_idx(k_idx), .tile_m(tile_m),
        .tile_n(tile_n), .a_row_base(a_row_base), .b_col_base(b_col_base),
        .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_row(drain_row),
        .tile_done(tile_done), .done(done)
    );

    tile_scheduler #(.WIDTH(4), .HEIGHT(4), .M_SIZE(4), .N_SIZE(4), .K_SIZE(1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .busy(busy2),
        .acc_clr(acc_clr2), .feed_en(feed_en2), .k_idx(k_idx2), .tile_m(tile_m2),
        .tile_n(tile_n2), .a_row_base(a_row_base2), .b_col_base(b_col_base2),
        .drain_valid(drain_valid2), .drain_ready(1'b1), .drain_row(drain_row2),
        .tile_done(tile_done2), .done(done2)
    );

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".busy"}, busy, 0);
        chk({tag, ".acc_clr"}, acc_clr, 0);
        chk({tag, ".feed_en"}, feed_en, 0);
        chk({tag, ".k_idx"}, k_idx, 0);
        chk({tag, ".tile_m"}, tile_m, 0);
        chk({tag, ".tile_n"}, tile_n, 0);
        chk({tag, ".a_row_base"}, a_row_base, 0);
        chk({tag, ".b_col_base"}, b_col_base, 0);
        chk({tag, ".drain_valid"}, drain_valid, 0);
        chk({tag, ".drain_row"}, drain_row, 0);
        chk({tag, ".tile_done"}, tile_done, 0);
        chk({tag, ".done"}, done, 0);
    endtask

    initial begin
        int t, p;

        // Reset state
        step(3);
        rst = 1'b0;
        step();
        chk_idle("reset");

        // Nominal job with stray starts in FLUSH (cycle 20) and DONE (cycle 253)
        start = 1'b1;
        cyc = 0;
        step();
        start = 1'b0;
        for (int c = 1; c <= 255; c++) begin
            t = (c - 1) / 28;
            p = (c - 1) % 28;
            n_tdone += int'(tile_done);
            n_done  += int'(done);
            if (c <= 252) begin
                chk("nom.busy", busy, 1);
                chk("nom.acc_clr", acc_clr, p == 0);
                chk("nom.feed_en", feed_en, p >= 1 && p <= 16);
                if (p >= 1 && p <= 16) chk("nom.k_idx", k_idx, p - 1);
                chk("nom.drain_valid", drain_valid, p >= 23 && p <= 26);
                if (p >= 23 && p <= 26) chk("nom.drain_row", drain_row, p - 23);
                chk("nom.tile_done", tile_done, p == 27);
                chk("nom.done", done, 0);
                chk("nom.tile_m", tile_m, t / 3);
                chk("nom.tile_n", tile_n, t % 3);
                chk("nom.a_row_base", a_row_base, (t / 3) * 4);
                chk("nom.b_col_base", b_col_base, (t % 3) * 4);
            end else if (c == 253) begin
                chk("nom.done_pulse", done, 1);
                chk("nom.done_busy", busy, 1);
                chk("nom.done_tile_done", tile_done, 0);
            end else begin
                chk("nom.end_busy", busy, 0);
                chk("nom.end_done", done, 0);
                chk("nom.end_tile_m", tile_m, 0);
                chk("nom.end_tile_n", tile_n, 0);
            end
            start = (c == 20 || c == 253);
            step();
        end
        start = 1'b0;
        chk("nom.tile_done_count", n_tdone, 9);
        chk("nom.done_count", n_done, 1);

        // Drain backpressure on tile 0 at drain_row 2
        start = 1'b1;
        cyc = 0;
        step();
        start = 1'b0;
        step(24);
        chk("bp.row1", drain_row, 1);
        step();
        chk("bp.row2", drain_row, 2);
        drain_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("bp.hold_row", drain_row, 2);
            chk("bp.hold_valid", drain_valid, 1);
            step();
        end
        drain_ready = 1'b1;
        chk("bp.row2_release", drain_row, 2);
        step();
        chk("bp.row3", drain_row, 3);
        chk("bp.row3_valid", drain_valid, 1);
        step();
        chk("bp.tile_done", tile_done, 1);
        step();
        chk("bp.cycle34_clear", acc_clr, 1);
        chk("bp.cycle", cyc, 34);
        chk("bp.tile_n", tile_n, 1);
        chk("bp.b_col_base", b_col_base, 4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_idle("bp_abort");

        // Abort in DRAIN of tile 4 together with an accepted beat
        start = 1'b1;
        cyc = 0;
        step();
        start = 1'b0;
        step(136);
        chk("ab.drain_valid", drain_valid, 1);
        chk("ab.drain_row", drain_row, 1);
        chk("ab.tile_m", tile_m, 1);
        chk("ab.tile_n", tile_n, 1);
        chk("ab.a_row_base", a_row_base, 4);
        chk("ab.b_col_base", b_col_base, 4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_idle("abort");
        n_done = 0;
        n_tdone = 0;
        for (int i = 0; i < 40; i++) begin
            n_done  += int'(done);
            n_tdone += int'(tile_done);
            step();
        end
        chk("ab.no_done", n_done, 0);
        chk("ab.no_tile_done", n_tdone, 0);
        chk("ab.still_idle", busy, 0);

        // Reset during FEED of tile 3, then restart from tile (0,0)
        start = 1'b1;
        cyc = 0;
        step();
        start = 1'b0;
        step(89);
        chk("rm.feed_en", feed_en, 1);
        chk("rm.k_idx", k_idx, 4);
        chk("rm.tile_m", tile_m, 1);
        chk("rm.tile_n", tile_n, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk_idle("rst_mid");
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rm.restart_clear", acc_clr, 1);
        chk("rm.restart_tile_m", tile_m, 0);
        chk("rm.restart_tile_n", tile_n, 0);
        chk("rm.restart_busy", busy, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;

        // Single-tile configuration, K=1
        start2 = 1'b1;
        cyc = 0;
        step();
        start2 = 1'b0;
        for (int c = 1; c <= 15; c++) begin
            chk("sw.acc_clr", acc_clr2, c == 1);
            chk("sw.feed_en", feed_en2, c == 2);
            chk("sw.drain_valid", drain_valid2, c >= 9 && c <= 12);
            chk("sw.tile_done", tile_done2, c == 13);
            chk("sw.done", done2, c == 14);
            chk("sw.busy", busy2, c <= 14);
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
